// File: rtl/breakout_pkg.sv
// Shared types and colour constants for the Breakout frame renderer.
//   game_state_t : game-state FSM encoding (IDLE/PLAY/WON/LOST)
//   rgb_t        : packed 8:8:8 colour {r,g,b}
//   COL_*        : fixed colours for border, paddle and ball
//   ROW_COLOUR   : per-row brick colour, indexed by (row mod 4)
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2,
    ST_LOST = 2'd3
  } game_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK  = 24'h000000;
  localparam rgb_t COL_WHITE  = 24'hFFFFFF;
  localparam rgb_t COL_RED    = 24'hFF0000;
  localparam rgb_t COL_GREEN  = 24'h00FF00;
  localparam rgb_t COL_PADDLE = 24'h20A0FF;
  localparam rgb_t COL_BALL   = 24'hFFFF00;

  // Element 0 is the rightmost entry of the concatenation.
  localparam rgb_t [3:0] ROW_COLOUR = {
    rgb_t'(24'h3060E0),
    rgb_t'(24'h30C040),
    rgb_t'(24'hF09020),
    rgb_t'(24'hE03030)
  };

endpackage

// File: rtl/brick_map.sv
// Live-brick bitmap, live-brick counter and the brick-hit handshake.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   play            : game is in PLAY (hits accepted only then)
//   refill          : restore every brick and reload the counter
//   hit_valid/_row/_col, hit_ready : hit request handshake
//   bricks_left     : number of live bricks
//   alive           : bitmap, bit r*N_COLS+c is brick (r,c)
module brick_map
  import breakout_pkg::*;
#(
  parameter int N_ROWS = 3,
  parameter int N_COLS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     play,
  input  logic                     refill,
  input  logic                     hit_valid,
  input  logic [2:0]               hit_row,
  input  logic [3:0]               hit_col,
  output logic                     hit_ready,
  output logic [7:0]               bricks_left,
  output logic [N_ROWS*N_COLS-1:0] alive
);

  localparam int         N_BRICKS   = N_ROWS * N_COLS;
  localparam logic [7:0] FULL_COUNT = 8'(N_BRICKS);

  logic [N_BRICKS-1:0] hit_sel;
  logic                take;
  logic                live_hit;

  // One-hot decode of the addressed brick. Out-of-range indices match no
  // comparator, so they are consumed without touching the bitmap.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      assign hit_sel[r*N_COLS+c] = (hit_row == 3'(r)) && (hit_col == 4'(c));
    end
  end

  assign hit_ready = play;
  // A start in the same cycle refills the wall and the hit is dropped.
  assign take      = hit_valid & play & ~refill;
  assign live_hit  = take & (|(hit_sel & alive));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive       <= '1;
      bricks_left <= FULL_COUNT;
    end else if (refill) begin
      alive       <= '1;
      bricks_left <= FULL_COUNT;
    end else if (live_hit) begin
      alive       <= alive & ~hit_sel;
      bricks_left <= bricks_left - 8'd1;
    end
  end

endmodule

// File: rtl/breakout_frame_renderer.sv
// Breakout frame renderer: brick wall, paddle, ball and border for VGA.
// Ports:
//   CLOCK_50, reset        : clock, asynchronous active-low reset
//   posX, posY, pix_valid  : pixel position from the VGA timing generator
//   paddleX, ballX, ballY  : object positions
//   start, ball_lost       : game-control pulses
//   hit_valid/_row/_col, hit_ready : brick-hit handshake from ball physics
//   bricks_left, game_state: game status
//   VGA_R/G/B              : colour, 2 cycles after posX/posY/pix_valid
module breakout_frame_renderer
  import breakout_pkg::*;
#(
  parameter int COORD_W       = 11,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int N_COLS        = 5,
  parameter int N_ROWS        = 3,
  parameter int BRICK_W       = 128,
  parameter int BRICK_H       = 20,
  parameter int WALL_TOP      = 60,
  parameter int PADDLE_Y      = 450,
  parameter int PADDLE_H      = 20,
  parameter int PADDLE_HALF_W = 40,
  parameter int BALL_SIZE     = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [COORD_W-1:0] posX,
  input  logic [COORD_W-1:0] posY,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] paddleX,
  input  logic [COORD_W-1:0] ballX,
  input  logic [COORD_W-1:0] ballY,
  input  logic               start,
  input  logic               ball_lost,
  input  logic               hit_valid,
  input  logic [2:0]         hit_row,
  input  logic [3:0]         hit_col,
  output logic               hit_ready,
  output logic [7:0]         bricks_left,
  output logic [1:0]         game_state,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B
);

  typedef logic [COORD_W-1:0] coord_t;
  // One extra bit so paddle/ball edge sums never wrap.
  typedef logic [COORD_W:0]   ext_t;

  game_state_t                state;
  logic [N_ROWS*N_COLS-1:0]   alive;

  brick_map #(
    .N_ROWS(N_ROWS),
    .N_COLS(N_COLS)
  ) u_brick_map (
    .clk        (CLOCK_50),
    .rst_n      (reset),
    .play       (state == ST_PLAY),
    .refill     (start),
    .hit_valid  (hit_valid),
    .hit_row    (hit_row),
    .hit_col    (hit_col),
    .hit_ready  (hit_ready),
    .bricks_left(bricks_left),
    .alive      (alive)
  );

  // Game-state FSM. In PLAY a start outranks ball_lost, which outranks the
  // win check; the win check looks at the registered counter, so WON lands
  // the cycle after the final accepted hit.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_PLAY;
        ST_PLAY: begin
          if (!start) begin
            if (ball_lost)                state <= ST_LOST;
            else if (bricks_left == 8'd0) state <= ST_WON;
          end
        end
        default: if (start) state <= ST_PLAY;
      endcase
    end
  end

  assign game_state = state;

  // Brick-wall comparators: one X window per column, one Y window per row.
  logic [N_COLS-1:0] in_col;
  logic [N_ROWS-1:0] in_row;

  for (genvar c = 0; c < N_COLS; c++) begin : g_col_cmp
    localparam coord_t X_LO = coord_t'(c * BRICK_W);
    localparam coord_t X_HI = coord_t'((c + 1) * BRICK_W - 1);
    if (c == 0) begin : g_first
      assign in_col[c] = (posX <= X_HI);
    end else begin : g_rest
      assign in_col[c] = (posX >= X_LO) && (posX <= X_HI);
    end
  end

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row_cmp
    localparam coord_t Y_LO = coord_t'(WALL_TOP + r * BRICK_H);
    localparam coord_t Y_HI = coord_t'(WALL_TOP + (r + 1) * BRICK_H - 1);
    assign in_row[r] = (posY >= Y_LO) && (posY <= Y_HI);
  end

  // Rows are disjoint, so at most one row can claim the pixel.
  logic       brick_any;
  logic [2:0] brick_row;

  always_comb begin
    brick_any = 1'b0;
    brick_row = 3'd0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (in_row[r] && (|(in_col & alive[r*N_COLS +: N_COLS]))) begin
        brick_any = 1'b1;
        brick_row = 3'(r);
      end
    end
  end

  // Paddle span is clamped to [0, H_RES-1] so a paddle near the left edge
  // cannot wrap round to the top of the coordinate range.
  localparam ext_t HALF_W = ext_t'(PADDLE_HALF_W);
  localparam ext_t X_MAX  = ext_t'(H_RES - 1);

  ext_t pad_lo, pad_hi_raw, pad_hi, pos_x_ext, pos_y_ext, ball_x_end, ball_y_end;
  logic paddle_hit, ball_hit, border_hit;

  assign pos_x_ext  = ext_t'(posX);
  assign pos_y_ext  = ext_t'(posY);
  assign pad_lo     = (ext_t'(paddleX) >= HALF_W) ? ext_t'(paddleX) - HALF_W : '0;
  assign pad_hi_raw = ext_t'(paddleX) + HALF_W;
  assign pad_hi     = (pad_hi_raw > X_MAX) ? X_MAX : pad_hi_raw;
  assign ball_x_end = ext_t'(ballX) + ext_t'(BALL_SIZE);
  assign ball_y_end = ext_t'(ballY) + ext_t'(BALL_SIZE);

  assign paddle_hit = (pos_x_ext >= pad_lo) && (pos_x_ext <= pad_hi) &&
                      (posY >= coord_t'(PADDLE_Y)) &&
                      (posY <  coord_t'(PADDLE_Y + PADDLE_H));
  assign ball_hit   = (pos_x_ext >= ext_t'(ballX)) && (pos_x_ext < ball_x_end) &&
                      (pos_y_ext >= ext_t'(ballY)) && (pos_y_ext < ball_y_end);
  assign border_hit = (posX == '0) || (posX == coord_t'(H_RES - 1)) ||
                      (posY == '0) || (posY == coord_t'(V_RES - 1));

  // Stage 1: region flags and the row of the live brick under the pixel.
  logic       v1, border1, ball1, paddle1, brick1;
  logic [2:0] row1;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      v1      <= 1'b0;
      border1 <= 1'b0;
      ball1   <= 1'b0;
      paddle1 <= 1'b0;
      brick1  <= 1'b0;
      row1    <= 3'd0;
    end else begin
      v1      <= pix_valid;
      border1 <= border_hit;
      ball1   <= ball_hit;
      paddle1 <= paddle_hit;
      brick1  <= brick_any;
      row1    <= brick_row;
    end
  end

  // Stage 2 colour select; state-dependent choices use the current state.
  rgb_t colour_next, colour_q;

  always_comb begin
    colour_next = COL_BLACK;
    if (v1) begin
      if (border1) begin
        case (state)
          ST_WON:  colour_next = COL_GREEN;
          ST_LOST: colour_next = COL_RED;
          default: colour_next = COL_WHITE;
        endcase
      end else if (ball1 && (state == ST_PLAY)) begin
        colour_next = COL_BALL;
      end else if (paddle1) begin
        colour_next = COL_PADDLE;
      end else if (brick1 && (state != ST_LOST)) begin
        colour_next = ROW_COLOUR[row1[1:0]];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) colour_q <= COL_BLACK;
    else        colour_q <= colour_next;
  end

  assign VGA_R = colour_q.r;
  assign VGA_G = colour_q.g;
  assign VGA_B = colour_q.b;

endmodule

// File: tb/tb_breakout_frame_renderer.sv
// Directed self-checking bench for breakout_frame_renderer (default params).
module tb_breakout_frame_renderer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [10:0] posX, posY, paddleX, ballX, ballY;
  logic        pix_valid, start, ball_lost, hit_valid;
  logic [2:0]  hit_row;
  logic [3:0]  hit_col;
  logic        hit_ready;
  logic [7:0]  bricks_left;
  logic [1:0]  game_state;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  logic [23:0] rgb;
  assign rgb = {VGA_R, VGA_G, VGA_B};

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] PADDLE = 24'h20A0FF;
  localparam logic [23:0] BALL   = 24'hFFFF00;
  localparam logic [23:0] ROW0   = 24'hE03030;
  localparam logic [23:0] ROW1   = 24'hF09020;
  localparam logic [23:0] ROW2   = 24'h30C040;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  breakout_frame_renderer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .posX       (posX),
    .posY       (posY),
    .pix_valid  (pix_valid),
    .paddleX    (paddleX),
    .ballX      (ballX),
    .ballY      (ballY),
    .start      (start),
    .ball_lost  (ball_lost),
    .hit_valid  (hit_valid),
    .hit_row    (hit_row),
    .hit_col    (hit_col),
    .hit_ready  (hit_ready),
    .bricks_left(bricks_left),
    .game_state (game_state),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cycle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y, input logic v);
    posX      = 11'(x);
    posY      = 11'(y);
    pix_valid = v;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] observed,
                             input logic [23:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pixelCheck(input string tag, input int x, input int y,
                            input logic [23:0] expected);
    applyStimulus(x, y, 1'b1);
    cycle(2);
    checkOutput(tag, rgb, expected);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
  endtask

  task automatic sendHit(input int r, input int c, input logic lost);
    hit_valid = 1'b1;
    hit_row   = 3'(r);
    hit_col   = 4'(c);
    ball_lost = lost;
    cycle(1);
    hit_valid = 1'b0;
    ball_lost = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ball_lost = 1'b0; hit_valid = 1'b0;
    hit_row = 3'd0; hit_col = 4'd0;
    paddleX = 11'd320; ballX = 11'd100; ballY = 11'd200;
    applyStimulus(10, 70, 1'b1);
    #2;
    checkOutput("rgb_in_reset", rgb, BLACK);
    #19 reset = 1'b1;
    cycle(2);
    checkOutput("first_brick_row0", rgb, ROW0);
    checkOutput("reset_state", 24'(game_state), 24'd0);
    checkOutput("reset_bricks_left", 24'(bricks_left), 24'd15);
    checkOutput("reset_hit_ready", 24'(hit_ready), 24'd0);

    pulseStart();
    checkOutput("state_play", 24'(game_state), 24'd1);
    checkOutput("hit_ready_play", 24'(hit_ready), 24'd1);

    sendHit(0, 2, 1'b0);
    checkOutput("hit_r0c2", 24'(bricks_left), 24'd14);
    pixelCheck("cleared_brick_black", 300, 70, BLACK);
    pixelCheck("row1_colour", 300, 85, ROW1);
    pixelCheck("row2_colour", 300, 105, ROW2);
    pixelCheck("above_wall", 10, 59, BLACK);
    pixelCheck("row2_bottom_line", 10, 119, ROW2);
    pixelCheck("below_wall", 10, 120, BLACK);

    sendHit(0, 2, 1'b0);
    checkOutput("repeat_hit", 24'(bricks_left), 24'd14);
    sendHit(3, 0, 1'b0);
    checkOutput("row_out_of_range", 24'(bricks_left), 24'd14);
    sendHit(0, 7, 1'b0);
    checkOutput("col_out_of_range", 24'(bricks_left), 24'd14);

    pulseStart();
    checkOutput("restart_in_play_state", 24'(game_state), 24'd1);
    checkOutput("restart_in_play_refill", 24'(bricks_left), 24'd15);

    hit_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        hit_row = 3'(r);
        hit_col = 4'(c);
        cycle(1);
      end
    end
    hit_valid = 1'b0;
    checkOutput("all_cleared_count", 24'(bricks_left), 24'd0);
    checkOutput("still_play_after_last_hit", 24'(game_state), 24'd1);
    cycle(1);
    checkOutput("state_won", 24'(game_state), 24'd2);
    checkOutput("hit_ready_won", 24'(hit_ready), 24'd0);
    pixelCheck("border_green_won", 0, 0, GREEN);

    pulseStart();
    checkOutput("won_to_play", 24'(game_state), 24'd1);
    checkOutput("won_refill", 24'(bricks_left), 24'd15);

    hit_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      hit_row = 3'(i / 5);
      hit_col = 4'(i % 5);
      cycle(1);
    end
    hit_valid = 1'b0;
    checkOutput("one_brick_left", 24'(bricks_left), 24'd1);
    sendHit(2, 4, 1'b1);
    checkOutput("last_hit_applied", 24'(bricks_left), 24'd0);
    checkOutput("state_lost", 24'(game_state), 24'd3);
    cycle(1);
    checkOutput("lost_over_won", 24'(game_state), 24'd3);
    pixelCheck("border_red_lost", 0, 0, RED);

    pulseStart();
    checkOutput("lost_to_play", 24'(game_state), 24'd1);
    checkOutput("lost_refill", 24'(bricks_left), 24'd15);

    ball_lost = 1'b1;
    cycle(1);
    ball_lost = 1'b0;
    checkOutput("ball_lost_full_wall", 24'(game_state), 24'd3);
    pixelCheck("bricks_hidden_lost", 10, 70, BLACK);

    pulseStart();
    pixelCheck("ball_inside", 103, 204, BALL);
    pixelCheck("ball_top_left", 100, 200, BALL);
    pixelCheck("ball_right_edge_excl", 108, 204, BLACK);

    paddleX = 11'd10;
    for (int x = 0; x <= 60; x++) begin
      applyStimulus(x, 455, 1'b1);
      cycle(2);
      checkOutput($sformatf("paddle_x%0d", x), rgb,
                  (x == 0) ? WHITE : ((x <= 50) ? PADDLE : BLACK));
    end
    pixelCheck("no_wrap_x2047", 2047, 455, BLACK);
    pixelCheck("right_border", 639, 455, WHITE);
    paddleX = 11'd630;
    pixelCheck("paddle_clamp_right", 638, 455, PADDLE);

    applyStimulus(10, 70, 1'b0);
    cycle(2);
    checkOutput("blanking_black", rgb, BLACK);
    pixelCheck("unblanked_brick", 10, 70, ROW0);

    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_rgb", rgb, BLACK);
    checkOutput("async_reset_state", 24'(game_state), 24'd0);
    checkOutput("async_reset_bricks", 24'(bricks_left), 24'd15);
    cycle(2);
    reset = 1'b1;
    cycle(1);
    checkOutput("resume_not_yet", rgb, BLACK);
    cycle(1);
    checkOutput("resume_after_2", rgb, ROW0);

    ball_lost = 1'b1;
    cycle(1);
    ball_lost = 1'b0;
    checkOutput("ball_lost_ignored_idle", 24'(game_state), 24'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
